uart_cmd_controller: RTL

- Frame-level command controller between the FPGA-PC UART byte interface and a local 8-bit register bank.
- Collects 5-byte command frames from the UART RX byte stream, checks them, and performs one register write or read.
- Returns a 4-byte response frame by sequencing the UART TX byte handshake.
- Single owner of the TX byte port; the PC is the only requester.

---
 rtl/uart_cmd_controller.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_controller.sv
// UART command-frame controller: receives A5/CMD/ADDR/DATA/CSUM frames,
// performs one register write or read, and answers with a 4-byte frame.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   rx_valid, rx_data     received byte strobe and value
//   tx_valid, tx_data     transmit request strobe and byte
//   tx_busy, tx_done      transmitter status and byte-complete strobe
//   reg_wr_en, reg_rd_en  one-cycle register write / read strobes
//   reg_addr, reg_wdata   register address and write data
//   reg_rdata             register read data (valid 1 cycle after reg_rd_en)
//   busy                  controller not idle
//   err_count             saturating count of rejected frames
module uart_cmd_controller #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] RESP_BYTE      = 8'h5A,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         TIMEOUT_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] err_count
);

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CSUM,
        EXEC,
        RD_WAIT,
        TX_LOAD,
        TX_WAIT
    } state_t;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [TIMEOUT_W-1:0] T_LAST =
        TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic [7:0]           cmd;
    logic [7:0]           addr;
    logic [7:0]           data;
    logic [7:0]           csum;
    logic [7:0]           status;
    logic [7:0]           resp_data;
    logic [1:0]           idx;
    logic [TIMEOUT_W-1:0] tcnt;
    logic [7:0]           tx_byte;
    logic [7:0]           csum_calc;
    logic [7:0]           err_inc;
    logic                 timed_out;

    assign csum_calc = cmd ^ addr ^ data;
    assign timed_out = (tcnt == T_LAST);
    assign err_inc   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    assign busy      = (state != IDLE);

    always_comb begin
        tx_byte = RESP_BYTE;
        unique case (idx)
            2'd0: tx_byte = RESP_BYTE;
            2'd1: tx_byte = status;
            2'd2: tx_byte = resp_data;
            2'd3: tx_byte = status ^ resp_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err_count <= '0;
            cmd       <= '0;
            addr      <= '0;
            data      <= '0;
            csum      <= '0;
            status    <= '0;
            resp_data <= '0;
            idx       <= '0;
            tcnt      <= '0;
        end else begin
            tx_valid  <= 1'b0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        tcnt  <= '0;
                        state <= GET_CMD;
                    end
                end
                GET_CMD, GET_ADDR, GET_DATA, GET_CSUM: begin
                    if (rx_valid) begin
                        tcnt <= '0;
                        if (state == GET_CMD) begin
                            cmd   <= rx_data;
                            state <= GET_ADDR;
                        end else if (state == GET_ADDR) begin
                            addr  <= rx_data;
                            state <= GET_DATA;
                        end else if (state == GET_DATA) begin
                            data  <= rx_data;
                            state <= GET_CSUM;
                        end else begin
                            // Strobes are launched here so they are
                            // high during the EXEC cycle itself.
                            csum  <= rx_data;
                            state <= EXEC;
                            if (csum_calc == rx_data) begin
                                if (cmd == CMD_WR) begin
                                    reg_wr_en <= 1'b1;
                                    reg_addr  <= addr;
                                    reg_wdata <= data;
                                end else if (cmd == CMD_RD) begin
                                    reg_rd_en <= 1'b1;
                                    reg_addr  <= addr;
                                end
                            end
                        end
                    end else if (timed_out) begin
                        state     <= IDLE;
                        err_count <= err_inc;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                EXEC: begin
                    idx <= '0;
                    if (csum_calc != csum) begin
                        status    <= 8'h01;
                        resp_data <= 8'h00;
                        err_count <= err_inc;
                        state     <= TX_LOAD;
                    end else if (cmd != CMD_WR && cmd != CMD_RD) begin
                        status    <= 8'h02;
                        resp_data <= 8'h00;
                        err_count <= err_inc;
                        state     <= TX_LOAD;
                    end else if (cmd == CMD_WR) begin
                        status    <= 8'h00;
                        resp_data <= data;
                        state     <= TX_LOAD;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    status    <= 8'h00;
                    resp_data <= reg_rdata;
                    state     <= TX_LOAD;
                end
                TX_LOAD: begin
                    if (!tx_busy) begin
                        tx_valid <= 1'b1;
                        tx_data  <= tx_byte;
                        state    <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        idx   <= idx + 2'd1;
                        state <= (idx == 2'd3) ? IDLE : TX_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
